// File: rtl/d_flip_flop.sv
// d_flip_flop: parameterised D-type register with synchronous active-high reset.
// WIDTH-bit data passes through STAGES cascaded flop stages before reaching Q.
// Q_n is the plain inverse of Q.
// Optional feature macro: D_FLIP_FLOP_EDGE_DET_EN adds registered per-bit
// rise/fall pulse outputs, one cycle after Q changes.

module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
`ifdef D_FLIP_FLOP_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  // Reject degenerate configurations while elaborating.
  if (WIDTH < 1) begin : g_bad_width
    $error("d_flip_flop: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("d_flip_flop: STAGES must be >= 1");
  end

  // Stage 0 holds the newest sample; the last stage drives Q.
  logic [STAGES-1:0][WIDTH-1:0] pipe;

  // Shift the pipeline on every rising edge; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe[i] <= RESET_VALUE;
      end
    end else begin
      pipe[0] <= D;
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign Q   = pipe[STAGES-1];
  assign Q_n = ~pipe[STAGES-1];

`ifdef D_FLIP_FLOP_EDGE_DET_EN
  // Copy of Q from the previous cycle, used to spot per-bit transitions.
  logic [WIDTH-1:0] q_prev;

  // Register rise/fall pulses; q_prev tracks the reset value on reset so the
  // reset transition never produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_prev <= RESET_VALUE;
      rise   <= '0;
      fall   <= '0;
    end else begin
      q_prev <= Q;
      rise   <= Q & ~q_prev;
      fall   <= ~Q & q_prev;
    end
  end
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed bench for d_flip_flop with three configurations
// (1-bit single stage, 8-bit three-stage, 4-bit with a non-zero reset value).
// A history-based model predicts Q, Q_n (and rise/fall when
// D_FLIP_FLOP_EDGE_DET_EN is defined) after every edge.

`timescale 1ns/1ps

module tb_d_flip_flop;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r0, r1, r2;
  logic       d0;
  logic [7:0] d1;
  logic [3:0] d2;
  logic       q0, qn0;
  logic [7:0] q1, qn1;
  logic [3:0] q2, qn2;
`ifdef D_FLIP_FLOP_EDGE_DET_EN
  logic       rise0, fall0;
  logic [7:0] rise1, fall1;
  logic [3:0] rise2, fall2;
`endif

  d_flip_flop #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) dut0 (
    .clk(clk), .reset(r0), .D(d0), .Q(q0), .Q_n(qn0)
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    , .rise(rise0), .fall(fall0)
`endif
  );

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h5A)) dut1 (
    .clk(clk), .reset(r1), .D(d1), .Q(q1), .Q_n(qn1)
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    , .rise(rise1), .fall(fall1)
`endif
  );

  d_flip_flop #(.WIDTH(4), .STAGES(1), .RESET_VALUE(4'b1010)) dut2 (
    .clk(clk), .reset(r2), .D(d2), .Q(q2), .Q_n(qn2)
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    , .rise(rise2), .fall(fall2)
`endif
  );

  // Uniform 8-bit views of each DUT's outputs.
  logic [7:0] qv [3];
  logic [7:0] qnv [3];
  assign qv[0]  = {7'b0, q0};
  assign qv[1]  = q1;
  assign qv[2]  = {4'b0, q2};
  assign qnv[0] = {7'b0, qn0};
  assign qnv[1] = qn1;
  assign qnv[2] = {4'b0, qn2};
`ifdef D_FLIP_FLOP_EDGE_DET_EN
  logic [7:0] rv_act [3];
  logic [7:0] fv_act [3];
  assign rv_act[0] = {7'b0, rise0};
  assign rv_act[1] = rise1;
  assign rv_act[2] = {4'b0, rise2};
  assign fv_act[0] = {7'b0, fall0};
  assign fv_act[1] = fall1;
  assign fv_act[2] = {4'b0, fall2};
`endif

  int testsRun = 0;
  int testsFailed = 0;

  // Model configuration and per-edge history of sampled D and reset.
  int         stg [3]     = '{1, 3, 1};
  logic [7:0] rst_val [3] = '{8'h00, 8'h5A, 8'h0A};
  logic [7:0] mask [3]    = '{8'h01, 8'hFF, 8'h0F};
  logic [7:0] dh [3][0:511];
  bit         rh [3][0:511];
  int         first_reset [3] = '{-1, -1, -1};
  int         edge_count = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Q after edge n: reset value if any reset was sampled within the last
  // STAGES edges, otherwise the D sampled STAGES-1 edges earlier.
  function automatic logic [7:0] expQ(int k, int n);
    int first = n - stg[k] + 1;
    for (int j = (first < 0) ? 0 : first; j <= n; j++) begin
      if (rh[k][j]) return rst_val[k];
    end
    if (first < 0) return rst_val[k];
    return dh[k][first] & mask[k];
  endfunction

  function automatic bit knownQ(int k, int n);
    return (first_reset[k] >= 0) && (first_reset[k] <= n);
  endfunction

`ifdef D_FLIP_FLOP_EDGE_DET_EN
  // Pulse after edge n reflects a Q transition at edge n-1; suppressed by a
  // reset at edge n or n-1.
  function automatic logic [7:0] expEdge(int k, int n, bit is_rise);
    logic [7:0] cur;
    logic [7:0] old;
    if (rh[k][n] || rh[k][n-1]) return 8'h00;
    cur = expQ(k, n - 1);
    old = expQ(k, n - 2);
    return is_rise ? (cur & ~old & mask[k]) : (~cur & old & mask[k]);
  endfunction
`endif

  // Record what each DUT sampled at this edge, then check outputs 1 ns later.
  int n_cur;
  always @(posedge clk) begin
    dh[0][edge_count] = {7'b0, d0};
    dh[1][edge_count] = d1;
    dh[2][edge_count] = {4'b0, d2};
    rh[0][edge_count] = r0;
    rh[1][edge_count] = r1;
    rh[2][edge_count] = r2;
    if (r0 && first_reset[0] < 0) first_reset[0] = edge_count;
    if (r1 && first_reset[1] < 0) first_reset[1] = edge_count;
    if (r2 && first_reset[2] < 0) first_reset[2] = edge_count;
    n_cur = edge_count;
    edge_count++;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (knownQ(k, n_cur)) begin
        checkOutput($sformatf("model_q%0d_e%0d", k, n_cur), qv[k], expQ(k, n_cur));
        checkOutput($sformatf("model_qn%0d_e%0d", k, n_cur), qnv[k], ~expQ(k, n_cur) & mask[k]);
      end
`ifdef D_FLIP_FLOP_EDGE_DET_EN
      if (n_cur >= 1 && knownQ(k, n_cur - 1)) begin
        checkOutput($sformatf("model_rise%0d_e%0d", k, n_cur), rv_act[k], expEdge(k, n_cur, 1'b1));
        checkOutput($sformatf("model_fall%0d_e%0d", k, n_cur), fv_act[k], expEdge(k, n_cur, 1'b0));
      end
`endif
    end
  end

  // Drive all inputs mid-cycle, then wait until just after the next edge.
  task automatic applyStimulus(input logic nd0, input logic nr0, input logic [7:0] nd1,
                               input logic nr1, input logic [3:0] nd2, input logic nr2);
    @(negedge clk);
    d0 = nd0; r0 = nr0;
    d1 = nd1; r1 = nr1;
    d2 = nd2; r2 = nr2;
    @(posedge clk);
    #2;
  endtask

  // Directed sequence with hand-computed expectations at key edges.
  initial begin
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    d0 = 1'b1; d1 = 8'hEE; d2 = 4'h3;
    @(posedge clk); #2;
    checkOutput("reset_q0_e0", {7'b0, q0}, 8'h00);
    checkOutput("reset_qn0_e0", {7'b0, qn0}, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, 4'h3, 1'b1);
    checkOutput("reset_q0_e1", {7'b0, q0}, 8'h00);
    checkOutput("reset_q1_e1", q1, 8'h5A);
    checkOutput("reset_q2_e1", {4'b0, q2}, 8'h0A);
    checkOutput("reset_qn2_e1", {4'b0, qn2}, 8'h05);
    // Tracking with one-cycle latency.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("track_q0_1", {7'b0, q0}, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("track_q0_0", {7'b0, q0}, 8'h00);
    checkOutput("track_qn0_0", {7'b0, qn0}, 8'h01);
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    checkOutput("rise0_pulse", {7'b0, rise0}, 8'h01);
`endif
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("track_q0_1b", {7'b0, q0}, 8'h01);
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    checkOutput("fall0_pulse", {7'b0, fall0}, 8'h01);
`endif
    // Hold D=1, then reset wins over D=1, then release with D=0.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("hold_q0", {7'b0, q0}, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("prio_q0", {7'b0, q0}, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("release_q0", {7'b0, q0}, 8'h00);
`ifdef D_FLIP_FLOP_EDGE_DET_EN
    checkOutput("no_fall_on_reset", {7'b0, fall0}, 8'h00);
`endif
    // Three-stage pipeline: sample at edge n shows after edge n+2.
    applyStimulus(1'b0, 1'b0, 8'hA5, 1'b0, 4'h3, 1'b0);
    checkOutput("pipe_q1_fill0", q1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0, 4'h3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0, 4'h3, 1'b0);
    checkOutput("pipe_q1_a5", q1, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 4'h3, 1'b0);
    checkOutput("pipe_q1_3c", q1, 8'h3C);
    applyStimulus(1'b0, 1'b0, 8'h11, 1'b0, 4'h3, 1'b0);
    checkOutput("pipe_q1_ff", q1, 8'hFF);
    checkOutput("pipe_qn1_ff", qn1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h12, 1'b0, 4'h3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h34, 1'b0, 4'h3, 1'b0);
    checkOutput("pipe_q1_11", q1, 8'h11);
    // Mid-stream reset flushes for three edges.
    applyStimulus(1'b0, 1'b0, 8'h56, 1'b1, 4'h3, 1'b0);
    checkOutput("flush_q1_a", q1, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h78, 1'b0, 4'h3, 1'b0);
    checkOutput("flush_q1_b", q1, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h9A, 1'b0, 4'h3, 1'b0);
    checkOutput("flush_q1_c", q1, 8'h5A);
    checkOutput("flush_qn1_c", qn1, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'hBC, 1'b0, 4'h3, 1'b0);
    checkOutput("flush_q1_78", q1, 8'h78);
    applyStimulus(1'b0, 1'b0, 8'hDE, 1'b0, 4'h3, 1'b0);
    checkOutput("flush_q1_9a", q1, 8'h9A);
    // Non-zero reset value, then a between-edge reset pulse.
    applyStimulus(1'b0, 1'b0, 8'hDE, 1'b0, 4'h3, 1'b1);
    checkOutput("rv_q2", {4'b0, q2}, 8'h0A);
    checkOutput("rv_qn2", {4'b0, qn2}, 8'h05);
    applyStimulus(1'b0, 1'b0, 8'hDE, 1'b0, 4'h6, 1'b0);
    checkOutput("rv_release_q2", {4'b0, q2}, 8'h06);
    @(negedge clk);
    #1 r2 = 1'b1;
    #1 checkOutput("async_mid_q2", {4'b0, q2}, 8'h06);
    #1 r2 = 1'b0;
    @(posedge clk); #2;
    checkOutput("async_after_q2", {4'b0, q2}, 8'h06);
    applyStimulus(1'b0, 1'b0, 8'hDE, 1'b0, 4'h9, 1'b0);
    checkOutput("track_q2_9", {4'b0, q2}, 8'h09);
    checkOutput("track_qn2_9", {4'b0, qn2}, 8'h06);
    applyStimulus(1'b0, 1'b0, 8'hDE, 1'b0, 4'h9, 1'b0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
